multi_alarm_clock: RTL

//  Parametrised successor of the single-alarm clock core: HH:MM timekeeping plus a bank of
//  NUM_ALARMS independently enabled alarms with snooze and ring timeout. Sits between the

---
 rtl/clock_pkg.sv | 34 +++
 rtl/multi_alarm_clock_if.sv | 42 ++++
 rtl/alarm_bank.sv | 61 ++++++
 rtl/multi_alarm_clock.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and helpers for the multi-alarm clock.
// Time is carried as a packed HH:MM pair throughout.
package clock_pkg;

   localparam int MIN_W        = 6;
   localparam int HOUR_W       = 5;
   localparam int MINS_PER_DAY = 1440;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  min;
   } hhmm_t;

   typedef enum logic [1:0] {
      IDLE,
      RING,
      SNOOZE
   } ring_state_e;

   function automatic hhmm_t hhmm_add(hhmm_t t, int m);
      int    tot;
      hhmm_t r;
      tot    = (int'(t.hour) * 60 + int'(t.min) + m) % MINS_PER_DAY;
      r.hour = HOUR_W'(tot / 60);
      r.min  = MIN_W'(tot % 60);
      return r;
   endfunction

   function automatic logic hhmm_ok(logic [MIN_W-1:0] m,
                                    logic [HOUR_W-1:0] h);
      return (m <= MIN_W'(59)) && (h <= HOUR_W'(23));
   endfunction

endpackage

// File: rtl/multi_alarm_clock_if.sv
// Settings/display bundle between the controller and the clock core.
// master = settings controller side, slave = clock core.
interface multi_alarm_clock_if #(
   parameter int NUM_ALARMS = 4
);
   import clock_pkg::*;

   localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

   logic                  load_time;
   logic                  load_alarm;
   logic [SEL_W-1:0]      alarm_sel;
   logic                  alarm_en_wr;
   logic                  alarm_en_val;
   logic [MIN_W-1:0]      set_min;
   logic [HOUR_W-1:0]     set_hour;
   logic                  snooze_btn;
   logic                  stop_btn;
   logic [MIN_W-1:0]      minutes;
   logic [HOUR_W-1:0]     hours;
   logic [MIN_W-1:0]      rd_alarm_min;
   logic [HOUR_W-1:0]     rd_alarm_hour;
   logic [NUM_ALARMS-1:0] alarm_en;
   logic                  ringing;
   logic [SEL_W-1:0]      ring_id;
   logic                  alarm_trigger;

   modport master (
      output load_time, load_alarm, alarm_sel, alarm_en_wr,
             alarm_en_val, set_min, set_hour, snooze_btn, stop_btn,
      input  minutes, hours, rd_alarm_min, rd_alarm_hour,
             alarm_en, ringing, ring_id, alarm_trigger
   );

   modport slave (
      input  load_time, load_alarm, alarm_sel, alarm_en_wr,
             alarm_en_val, set_min, set_hour, snooze_btn, stop_btn,
      output minutes, hours, rd_alarm_min, rd_alarm_hour,
             alarm_en, ringing, ring_id, alarm_trigger
   );

endinterface

// File: rtl/alarm_bank.sv
// Alarm slot storage, enables, read mux and lowest-index
// match encoder against the current time.
module alarm_bank
   import clock_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int SEL_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic                  en_wr_i,
   input  logic                  en_val_i,
   input  logic [SEL_W-1:0]      sel_i,
   input  hhmm_t                 wdata_i,
   input  hhmm_t                 now_i,
   output hhmm_t                 rdata_o,
   output logic [NUM_ALARMS-1:0] en_o,
   output logic                  match_o,
   output logic [SEL_W-1:0]      match_id_o
);

   hhmm_t                 slot_q [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] en_q;
   logic                  sel_ok;

   assign sel_ok = int'(sel_i) < NUM_ALARMS;
   assign en_o   = en_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ALARMS; i++)
            slot_q[i] <= '0;
         en_q <= '0;
      end else begin
         if (load_i && sel_ok)
            slot_q[sel_i] <= wdata_i;
         if (en_wr_i && sel_ok)
            en_q[sel_i] <= en_val_i;
      end
   end

   always_comb begin
      rdata_o = '0;
      if (sel_ok)
         rdata_o = slot_q[sel_i];
   end

   // Scan high to low so the lowest matching slot is left standing.
   always_comb begin
      match_o    = 1'b0;
      match_id_o = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (en_q[i] && (slot_q[i] == now_i)) begin
            match_o    = 1'b1;
            match_id_o = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/multi_alarm_clock.sv
// HH:MM timekeeping with a bank of alarms, snooze and ring
// timeout; tick, time counters and ring FSM live here.
module multi_alarm_clock
   import clock_pkg::*;
#(
   parameter int TICK_COUNT_MAX = 10000000,
   parameter int NUM_ALARMS     = 4,
   parameter int SNOOZE_MIN     = 5,
   parameter int RING_TIMEOUT   = 3
) (
   input logic                clk,
   input logic                rst,
   multi_alarm_clock_if.slave ctl
);

   localparam int SEL_W =
      (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
   localparam int CNT_W =
      (TICK_COUNT_MAX > 1) ? $clog2(TICK_COUNT_MAX) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   hhmm_t            time_q, time_d;
   logic             chg_q, chg_d;
   ring_state_e      state_q, state_d;
   logic [3:0]       ring_min_cnt_q;
   logic [SEL_W-1:0] ring_id_q;
   logic             trig_q;
   hhmm_t            snz_q;

   logic             tick, load_ok, alarm_ok, dis;
   logic             match;
   logic [SEL_W-1:0] match_id;
   hhmm_t            set_val, rd_val;
   logic             enter_ring;

   assign set_val  = '{hour: ctl.set_hour, min: ctl.set_min};
   assign tick     = cnt_q == CNT_W'(TICK_COUNT_MAX - 1);
   assign load_ok  = ctl.load_time &&
                     hhmm_ok(ctl.set_min, ctl.set_hour);
   assign alarm_ok = ctl.load_alarm &&
                     hhmm_ok(ctl.set_min, ctl.set_hour);
   assign dis      = ctl.alarm_en_wr && !ctl.alarm_en_val &&
                     (ctl.alarm_sel == ring_id_q);

   alarm_bank #(
      .NUM_ALARMS(NUM_ALARMS),
      .SEL_W     (SEL_W)
   ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .load_i    (alarm_ok),
      .en_wr_i   (ctl.alarm_en_wr),
      .en_val_i  (ctl.alarm_en_val),
      .sel_i     (ctl.alarm_sel),
      .wdata_i   (set_val),
      .now_i     (time_q),
      .rdata_o   (rd_val),
      .en_o      (ctl.alarm_en),
      .match_o   (match),
      .match_id_o(match_id)
   );

   // A load overrides the tick and restarts the minute.
   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      time_d = time_q;
      chg_d  = load_ok || tick;
      if (load_ok) begin
         cnt_d  = '0;
         time_d = set_val;
      end else if (tick) begin
         cnt_d  = '0;
         time_d = hhmm_add(time_q, 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         time_q <= '0;
         chg_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         time_q <= time_d;
         chg_q  <= chg_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (chg_q && match)
               state_d = RING;
         RING:
            if (ctl.stop_btn || dis)
               state_d = IDLE;
            else if (ctl.snooze_btn)
               state_d = SNOOZE;
            else if (tick && ring_min_cnt_q ==
                     4'(RING_TIMEOUT - 1))
               state_d = IDLE;
         SNOOZE:
            if (ctl.stop_btn || dis)
               state_d = IDLE;
            else if (chg_q && time_q == snz_q)
               state_d = RING;
         default:
            state_d = IDLE;
      endcase
   end

   assign enter_ring = (state_d == RING) && (state_q != RING);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ring_min_cnt_q <= '0;
         ring_id_q      <= '0;
         trig_q         <= 1'b0;
         snz_q          <= '0;
      end else begin
         trig_q <= enter_ring;
         if (enter_ring)
            ring_min_cnt_q <= '0;
         else if (state_q == RING && tick)
            ring_min_cnt_q <= ring_min_cnt_q + 1'b1;
         if (state_q == IDLE && enter_ring)
            ring_id_q <= match_id;
         if (state_q == RING && state_d == SNOOZE)
            snz_q <= hhmm_add(time_q, SNOOZE_MIN);
      end
   end

   always_comb begin
      ctl.ringing       = state_q == RING;
      ctl.alarm_trigger = trig_q;
      ctl.ring_id       = ring_id_q;
      ctl.minutes       = time_q.min;
      ctl.hours         = time_q.hour;
      ctl.rd_alarm_min  = rd_val.min;
      ctl.rd_alarm_hour = rd_val.hour;
   end

endmodule
